// File: rtl/program_memory_loader.sv
// Program memory loader: assembles a length-prefixed byte stream into 32-bit words and writes them
// into the program RAM, holding the CPU in reset until the load completes.
module program_memory_loader #(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start_i,
  input  logic [7:0]            byte_data_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  cpu_hold_o,
  output logic                  load_done_o,
  output logic                  load_error_o
);

  // Wide enough to hold MEMORY_DEPTH itself, so index_next can reach N.
  localparam int unsigned IdxW = $clog2(MEMORY_DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StCollect,
    StWrite,
    StDone,
    StError
  } state_e;

  state_e                state_q;
  logic [7:0]            len_hi_q;
  logic [15:0]           word_count_q;
  logic [IdxW-1:0]       word_index_q;
  logic [1:0]            byte_cnt_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  xfer;
  logic [15:0]           len_full;
  logic [IdxW-1:0]       index_next;
  logic [DATA_WIDTH-1:0] data_shift;
  logic                  last_word;

  // Ready is registered, so the handshake is stable for the whole cycle.
  assign xfer       = byte_valid_i & byte_ready_o;
  assign len_full   = {len_hi_q, byte_data_i};
  assign index_next = word_index_q + IdxW'(1);
  assign data_shift = {data_q[DATA_WIDTH-9:0], byte_data_i};
  assign last_word  = (32'(index_next) == 32'(word_count_q));

  // Load FSM with all outputs registered on state entry/exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      len_hi_q      <= '0;
      word_count_q  <= '0;
      word_index_q  <= '0;
      byte_cnt_q    <= '0;
      data_q        <= '0;
      byte_ready_o  <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_address_o <= '0;
      mem_data_o    <= '0;
      cpu_hold_o    <= 1'b0;
      load_done_o   <= 1'b0;
      load_error_o  <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (load_start_i) begin
            state_q      <= StLenHi;
            word_index_q <= '0;
            byte_cnt_q   <= '0;
            byte_ready_o <= 1'b1;
            cpu_hold_o   <= 1'b1;
            load_done_o  <= 1'b0;
            load_error_o <= 1'b0;
          end
        end
        StLenHi: begin
          if (xfer) begin
            len_hi_q <= byte_data_i;
            state_q  <= StLenLo;
          end
        end
        StLenLo: begin
          if (xfer) begin
            word_count_q <= len_full;
            word_index_q <= '0;
            byte_cnt_q   <= '0;
            if (32'(len_full) > MEMORY_DEPTH) begin
              state_q      <= StError;
              byte_ready_o <= 1'b0;
              load_error_o <= 1'b1;
            end else if (len_full == 16'd0) begin
              state_q      <= StDone;
              byte_ready_o <= 1'b0;
              cpu_hold_o   <= 1'b0;
              load_done_o  <= 1'b1;
            end else begin
              state_q <= StCollect;
            end
          end
        end
        StCollect: begin
          if (xfer) begin
            data_q     <= data_shift;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q       <= StWrite;
              byte_ready_o  <= 1'b0;
              mem_we_o      <= 1'b1;
              mem_address_o <= BASE_ADDRESS + (32'(word_index_q) << 2);
              mem_data_o    <= data_shift;
            end
          end
        end
        StWrite: begin
          word_index_q <= index_next;
          if (last_word) begin
            state_q     <= StDone;
            cpu_hold_o  <= 1'b0;
            load_done_o <= 1'b1;
          end else begin
            state_q      <= StCollect;
            byte_ready_o <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader: a stream-level model predicts the RAM writes and
// the final status of each load; a monitor checks every write as it happens.
module tb_program_memory_loader;

  localparam int unsigned Depth = 32;
  localparam logic [31:0] Base  = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        load_start_i;
  logic [7:0]  byte_data_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;
  logic        cpu_hold_o;
  logic        load_done_o;
  logic        load_error_o;

  program_memory_loader #(
    .MEMORY_DEPTH(Depth),
    .DATA_WIDTH  (32),
    .BASE_ADDRESS(Base)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start_i (load_start_i),
    .byte_data_i  (byte_data_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_address_o(mem_address_o),
    .mem_data_o   (mem_data_o),
    .cpu_hold_o   (cpu_hold_o),
    .load_done_o  (load_done_o),
    .load_error_o (load_error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];  // {address, data} the model expects, in order
  logic [63:0] got_q[$];  // {address, data} the DUT actually wrote
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: from the stream alone, decide the outcome and the list of writes.
  task automatic model_load(input logic [7:0] s[$], output bit is_err);
    int n;
    n = int'({s[0], s[1]});
    exp_q.delete();
    is_err = (n > int'(Depth));
    if (!is_err) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({Base + 32'(4 * i),
                         s[2 + 4 * i], s[3 + 4 * i], s[4 + 4 * i], s[5 + 4 * i]});
      end
    end
  endtask

  // Every write is checked against the model as it occurs.
  always @(negedge clk) begin
    if (mon_en && reset && mem_we_o) begin
      logic [63:0] e;
      got_q.push_back({mem_address_o, mem_data_o});
      check("ready_in_write", 64'(byte_ready_o), 64'd0);
      check("hold_in_write", 64'(cpu_hold_o), 64'd1);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                 mem_address_o, mem_data_o);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_address_o), 64'(e[63:32]));
        check("wr_data", 64'(mem_data_o), 64'(e[31:0]));
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    load_start_i = 1'b1;
    @(negedge clk);
    load_start_i = 1'b0;
    check("start_flags", 64'({byte_ready_o, cpu_hold_o, load_done_o, load_error_o}), 64'b1100);
  endtask

  // Offer bytes with random gaps until `limit` have been accepted.
  task automatic send(input logic [7:0] s[$], input int gap, input int limit, input bit poke);
    int idx = 0;
    int budget = 4000;
    while (idx < limit && budget > 0) begin
      @(negedge clk);
      budget--;
      byte_valid_i = ($urandom_range(99) >= gap);
      byte_data_i  = s[idx];
      load_start_i = poke && (idx >= 2) && ($urandom_range(7) == 0);
      if (byte_valid_i && byte_ready_o) idx++;
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
    load_start_i = 1'b0;
    if (idx < limit) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: accepted %0d bytes, required %0d", idx, limit);
    end
  endtask

  task automatic wait_end(input bit is_err);
    int budget = 200;
    while (!(load_done_o || load_error_o) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (2) @(negedge clk);
    check("writes_left", 64'(exp_q.size()), 64'd0);
    check("end_done", 64'(load_done_o), 64'(!is_err));
    check("end_error", 64'(load_error_o), 64'(is_err));
    check("end_hold", 64'(cpu_hold_o), 64'(is_err));
    check("end_ready_we", 64'({byte_ready_o, mem_we_o}), 64'd0);
  endtask

  task automatic run_load(input logic [7:0] s[$], input int gap, input bit poke);
    bit is_err;
    model_load(s, is_err);
    pulse_start();
    send(s, gap, is_err ? 2 : s.size(), poke);
    wait_end(is_err);
  endtask

  logic [7:0] s2[$];
  logic [7:0] sr[$];

  initial begin
    reset = 1'b0;
    load_start_i = 1'b0;
    byte_data_i = 8'h00;
    byte_valid_i = 1'b0;
    s2 = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};

    // 1: reset state, then idle with valid asserted and no start
    repeat (3) @(negedge clk);
    check("reset_state", {mem_address_o, mem_data_o}, 64'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    byte_valid_i = 1'b1;
    byte_data_i = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_flags", 64'({byte_ready_o, mem_we_o, cpu_hold_o, load_done_o, load_error_o}),
            64'd0);
    end
    check("idle_bus", {mem_address_o, mem_data_o}, 64'd0);
    byte_valid_i = 1'b0;

    // 2: reference two-word load, no gaps, with literal expectations
    got_q.delete();
    run_load(s2, 0, 1'b0);
    check("t2_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check("t2_w0", got_q[0], 64'h0000_0000_2408_0005);
      check("t2_w1", got_q[1], 64'h0000_0004_0000_000C);
    end

    // 3: length 33 > depth -> error; then recover with a valid stream
    sr = '{8'h00, 8'h21};
    run_load(sr, 0, 1'b0);
    run_load(s2, 20, 1'b0);

    // 4: zero length -> done, no writes
    got_q.delete();
    sr = '{8'h00, 8'h00};
    run_load(sr, 0, 1'b0);
    check("t4_count", 64'(got_q.size()), 64'd0);

    // 5: random gaps plus start pulses mid-load are ignored
    got_q.delete();
    run_load(s2, 50, 1'b1);
    check("t5_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check("t5_w0", got_q[0], 64'h0000_0000_2408_0005);
      check("t5_w1", got_q[1], 64'h0000_0004_0000_000C);
    end

    // 6: reset after byte 2 of word 1 aborts; restart loads everything
    begin
      bit e6;
      model_load(s2, e6);
      pulse_start();
      send(s2, 0, 4, 1'b0);
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("abort_flags", 64'({byte_ready_o, mem_we_o, cpu_hold_o, load_done_o, load_error_o}),
            64'd0);
      check("abort_bus", {mem_address_o, mem_data_o}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      got_q.delete();
      run_load(s2, 30, 1'b0);
      check("t6_count", 64'(got_q.size()), 64'd2);
    end

    // Random loads including the depth boundary and oversize lengths
    for (int t = 0; t < 8; t++) begin
      int n;
      case (t)
        0:       n = int'(Depth);
        1:       n = int'(Depth) + 1;
        2:       n = 1;
        3:       n = int'($urandom_range(34, 65535));
        default: n = int'($urandom_range(1, Depth));
      endcase
      sr.delete();
      sr.push_back(8'(n >> 8));
      sr.push_back(8'(n));
      if (n <= int'(Depth)) begin
        for (int b = 0; b < 4 * n; b++) sr.push_back(8'($urandom));
      end
      run_load(sr, int'($urandom_range(0, 60)), (n > 0) && (n <= int'(Depth)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
